// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bc_pkg
// Description : Shared constants and helpers for the boundary-scan chain slice.
// Revision    : 1.0 - initial release
// ============================================================================

package bc_pkg;

   // Cell type selector for each bit of a scan segment
   localparam logic CELL_IN  = 1'b0;
   localparam logic CELL_OUT = 1'b1;

   // Counter width able to hold 0..width+1, so that overshift stays visible
   function automatic int bc_cnt_w(input int width);
      return $clog2(width + 2);
   endfunction

endpackage : bc_pkg

`default_nettype wire

// File: rtl/bc_cell.sv
`default_nettype none
// ============================================================================
// Module      : bc_cell
// Description : One boundary-scan bit: capture/shift flop, optional update
//               flop and the functional/test output mux.
// Revision    : 1.0 - initial release
// ============================================================================

module bc_cell
   import bc_pkg::*;
#(
   parameter logic IS_OUT  = CELL_OUT,
   parameter logic UPD_RST = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic capture_dr,
   input  logic shift_dr,
   input  logic upd_en,
   input  logic mode,
   input  logic shift_in,
   input  logic data_in,
   output logic cap_q,
   output logic data_out
);

   logic r_cap;

   // Capture has priority over shift when both strobes arrive together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap <= 1'b0;
      end else if (capture_dr) begin
         r_cap <= data_in;
      end else if (shift_dr) begin
         r_cap <= shift_in;
      end
   end

   assign cap_q = r_cap;

   generate
      if (IS_OUT == CELL_OUT) begin : g_out_cell
         logic r_upd;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_upd <= UPD_RST;
            end else if (upd_en) begin
               r_upd <= r_cap;
            end
         end

         assign data_out = mode ? r_upd : data_in;
      end else begin : g_in_cell
         // Input-only cells never drive test data; strobes are irrelevant here
         logic w_unused;
         assign w_unused = mode ^ upd_en;
         assign data_out = data_in;
      end
   endgenerate

endmodule : bc_cell

`default_nettype wire

// File: rtl/bc_chain_reg.sv
`default_nettype none
// ============================================================================
// Module      : bc_chain_reg
// Description : WIDTH-bit boundary-scan segment with capture, shift, update
//               and a shift-length checker that suppresses bad updates.
// Revision    : 1.0 - initial release
// ============================================================================

module bc_chain_reg
   import bc_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] OUT_MASK    = '1,
   parameter logic [WIDTH-1:0] UPD_RST_VAL = '0,
   parameter logic             CHK_LEN     = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          capture_dr,
   input  logic                          shift_dr,
   input  logic                          update_dr,
   input  logic                          mode,
   input  logic                          si,
   input  logic [WIDTH-1:0]              data_in,
   output logic [WIDTH-1:0]              data_out,
   output logic                          so,
   output logic [bc_cnt_w(WIDTH)-1:0]    shift_cnt,
   output logic                          upd_err
);

   localparam int          CW        = bc_cnt_w(WIDTH);
   localparam logic [CW-1:0] c_cnt_len = CW'(WIDTH);
   localparam logic [CW-1:0] c_cnt_sat = CW'(WIDTH + 1);

   logic [WIDTH:0]  w_chain;
   logic [CW-1:0]   r_cnt;
   logic            r_err;
   logic            w_legal;
   logic            w_upd_en;

   // w_chain[i] is cell i's capture bit; the top slot feeds serial input
   assign w_chain[WIDTH] = si;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         bc_cell #(
            .IS_OUT  (OUT_MASK[i]),
            .UPD_RST (UPD_RST_VAL[i])
         ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .capture_dr (capture_dr),
            .shift_dr   (shift_dr),
            .upd_en     (w_upd_en),
            .mode       (mode),
            .shift_in   (w_chain[i+1]),
            .data_in    (data_in[i]),
            .cap_q      (w_chain[i]),
            .data_out   (data_out[i])
         );
      end
   endgenerate

   // Zero shifts keeps the captured word; exactly WIDTH shifts loads a full new word
   assign w_legal  = (CHK_LEN == 1'b0) || (r_cnt == '0) || (r_cnt == c_cnt_len);
   assign w_upd_en = update_dr && w_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (capture_dr) begin
         r_cnt <= '0;
      end else if (shift_dr && (r_cnt != c_cnt_sat)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sticky until the next capture opens a fresh scan transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (capture_dr) begin
         r_err <= 1'b0;
      end else if (update_dr && !w_legal) begin
         r_err <= 1'b1;
      end
   end

   assign so        = w_chain[0];
   assign shift_cnt = r_cnt;
   assign upd_err   = r_err;

endmodule : bc_chain_reg

`default_nettype wire

// File: tb/tb_bc_chain_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_bc_chain_reg
// Description : Table-driven self-checking bench for bc_chain_reg.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_bc_chain_reg;

   logic       clk;
   logic       rst_n;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic       mode;
   logic       si;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       so;
   logic [3:0] shift_cnt;
   logic       upd_err;

   int n_vec;
   int n_fail;

   typedef struct {
      logic       rst_n;
      logic       cap;
      logic       shf;
      logic       upd;
      logic       mode;
      logic       si;
      logic [7:0] din;
      logic [7:0] exp_out;
      logic       exp_so;
      logic [3:0] exp_cnt;
      logic       exp_err;
   } vec_t;

   vec_t tbl[$];

   bc_chain_reg #(
      .WIDTH       (8),
      .OUT_MASK    (8'h0F),
      .UPD_RST_VAL (8'hA5),
      .CHK_LEN     (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .mode       (mode),
      .si         (si),
      .data_in    (data_in),
      .data_out   (data_out),
      .so         (so),
      .shift_cnt  (shift_cnt),
      .upd_err    (upd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic c, input logic s, input logic u,
                      input logic m, input logic i, input logic [7:0] d,
                      input logic [7:0] eo, input logic es, input logic [3:0] ec,
                      input logic ee);
      vec_t v;
      v.rst_n = r; v.cap = c; v.shf = s; v.upd = u; v.mode = m; v.si = i; v.din = d;
      v.exp_out = eo; v.exp_so = es; v.exp_cnt = ec; v.exp_err = ee;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] eo, input logic es,
                        input logic [3:0] ec, input logic ee);
      n_vec++;
      if (data_out !== eo || so !== es || shift_cnt !== ec || upd_err !== ee) begin
         n_fail++;
         $display("FAIL %s: got data_out=%h so=%b shift_cnt=%0d upd_err=%b, required data_out=%h so=%b shift_cnt=%0d upd_err=%b",
                  name, data_out, so, shift_cnt, upd_err, eo, es, ec, ee);
      end
   endtask

   task automatic strobe(input logic c, input logic s, input logic i, input logic [7:0] d);
      @(negedge clk);
      capture_dr = c; shift_dr = s; update_dr = 1'b0; si = i; data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] c3;
      logic [7:0] v81;
      n_vec  = 0;
      n_fail = 0;
      rst_n = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      mode = 1'b1; si = 1'b0; data_in = 8'h3C;

      // Reset state: low nibble from reset value 4'h5, high nibble passthrough
      add(0,0,0,0,1,0,8'h3C, 8'h35,0,0,0);

      // Capture 8'hC3 then shift ones in; so walks the captured bits LSB first
      c3 = 8'hC3;
      add(1,1,0,0,1,0,8'hC3, 8'hC5,1,0,0);
      for (int k = 1; k <= 8; k++)
         add(1,0,1,0,1,1,8'hC3, 8'hC5, (k < 8) ? c3[k] : 1'b1, 4'(k), 0);
      add(1,0,0,1,1,0,8'hC3, 8'hCF,1,8,0);

      // Shift in 8'h96 LSB first, then a legal update
      pat = 8'h96;
      add(1,1,0,0,1,0,8'h00, 8'h0F,0,0,0);
      for (int k = 0; k < 8; k++)
         add(1,0,1,0,1,pat[k],8'h00, 8'h0F,0,4'(k+1),0);
      add(1,0,0,1,1,0,8'h00, 8'h06,0,8,0);

      // Functional mode passes data_in on every bit
      add(1,0,0,0,0,0,8'h5A, 8'h5A,0,8,0);
      add(1,0,0,0,0,0,8'hA5, 8'hA5,0,8,0);
      add(1,0,0,0,1,0,8'hF0, 8'hF6,0,8,0);

      // Short shift: update suppressed, flag sticky until capture
      add(0,0,0,0,1,0,8'h00, 8'h05,0,0,0);
      add(1,1,0,0,1,0,8'h00, 8'h05,0,0,0);
      for (int k = 1; k <= 5; k++)
         add(1,0,1,0,1,0,8'h00, 8'h05,0,4'(k),0);
      add(1,0,0,1,1,0,8'h00, 8'h05,0,5,1);
      add(1,0,0,0,1,0,8'h00, 8'h05,0,5,1);
      add(1,1,0,0,1,0,8'h00, 8'h05,0,0,0);

      // Capture beats shift; overshift saturates at WIDTH+1
      v81 = 8'h81;
      add(1,1,1,0,1,1,8'h81, 8'h85,1,0,0);
      for (int k = 1; k <= 12; k++)
         add(1,0,1,0,1,0,8'h00, 8'h05, (k < 8) ? v81[k] : 1'b0, (k < 9) ? 4'(k) : 4'd9, 0);
      add(1,0,0,1,1,0,8'h00, 8'h05,0,9,1);

      // Update straight after capture (zero shifts) is legal
      add(1,1,0,0,1,0,8'h0A, 8'h05,0,0,0);
      add(1,0,0,1,1,0,8'h0A, 8'h0A,0,0,0);

      foreach (tbl[n]) begin
         @(negedge clk);
         rst_n = tbl[n].rst_n; capture_dr = tbl[n].cap; shift_dr = tbl[n].shf;
         update_dr = tbl[n].upd; mode = tbl[n].mode; si = tbl[n].si; data_in = tbl[n].din;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", n), tbl[n].exp_out, tbl[n].exp_so, tbl[n].exp_cnt, tbl[n].exp_err);
      end

      // Combinational output path: no clock edge between change and check
      @(negedge clk);
      capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      mode = 1'b0; data_in = 8'h33;
      #1;
      check("mode0_comb", 8'h33, 0, 0, 0);
      mode = 1'b1;
      #1;
      check("mode1_comb", 8'h3A, 0, 0, 0);

      // Asynchronous reset in the middle of a shift
      mode = 1'b1;
      strobe(1, 0, 0, 8'hFF);
      strobe(0, 1, 0, 8'hFF);
      strobe(0, 1, 0, 8'hFF);
      check("pre_reset", 8'hFA, 1, 2, 0);
      @(posedge clk);
      #3;
      shift_dr = 1'b0; data_in = 8'h3C; rst_n = 1'b0;
      #1;
      check("async_reset", 8'h35, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_bc_chain_reg

`default_nettype wire
